video_dram_sched: RTL and testbench

Slot scheduler sharing the single DRAM read port among four requesters: the video bitmap fetcher, the tile-map reader, the tile/sprite renderer and the CPU. It decides once per DRAM slot, drives the DRAM address and request, and returns per-requester pre_next/next strobes aligned to the fixed read latency. It sits between video_top's DRAM interface and the DRAM controller.

---
 rtl/video_sched_pkg.sv | 15 +
 rtl/video_sched_pipe.sv | 38 +++
 rtl/video_dram_sched.sv | 127 ++++++++++++
 tb/tb_video_dram_sched.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_sched_pkg.sv
// Shared source encodings and defaults for the video DRAM slot scheduler.
package video_sched_pkg;

    localparam logic [1:0] SRC_VID = 2'd0;
    localparam logic [1:0] SRC_TM  = 2'd1;
    localparam logic [1:0] SRC_TS  = 2'd2;
    localparam logic [1:0] SRC_CPU = 2'd3;

    localparam int RD_LAT_DEF = 2;

    function automatic logic [3:0] src_onehot(input logic [1:0] src);
        return 4'b0001 << src;
    endfunction

endpackage

// File: rtl/video_sched_pipe.sv
// Read-latency delay line of granted sources; decodes the delivered entry into one next strobe.
module video_sched_pipe
    import video_sched_pkg::*;
#(
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic       clk,
    input  logic       res,
    input  logic       in_vld,
    input  logic [1:0] in_src,
    output logic [3:0] next
);

    logic [RD_LAT-1:0] vld_p;
    logic [1:0]        src_p [RD_LAT];

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= in_vld;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    // Source tags need no reset: they are only looked at when their valid bit is set.
    always_ff @(posedge clk) begin
        src_p[0] <= in_src;
        for (int i = 1; i < RD_LAT; i++) begin
            src_p[i] <= src_p[i-1];
        end
    end

    assign next = vld_p[RD_LAT-1] ? src_onehot(src_p[RD_LAT-1]) : 4'b0000;

endmodule

// File: rtl/video_dram_sched.sv
// Per-slot DRAM read-port arbiter: video burst > tile map > {TS, CPU} ordered by ts_lp.
module video_dram_sched
    import video_sched_pkg::*;
#(
    parameter int AW     = 21,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic          clk,
    input  logic          res,
    input  logic          slot,
    input  logic          video_go,
    input  logic [AW-1:0] video_addr,
    input  logic [4:0]    video_bw,
    input  logic          tm_req,
    input  logic [AW-1:0] tm_addr,
    input  logic          ts_req,
    input  logic [AW-1:0] ts_addr,
    input  logic          ts_lp,
    input  logic          cpu_req,
    input  logic          cpu_rnw,
    input  logic [AW-1:0] cpu_addr,
    output logic          dram_req,
    output logic [AW-1:0] dram_addr,
    output logic          dram_rnw,
    output logic          video_pre_next,
    output logic          tm_pre_next,
    output logic          ts_pre_next,
    output logic          cpu_pre_next,
    output logic          video_next,
    output logic          tm_next,
    output logic          ts_next,
    output logic          cpu_next,
    output logic          video_busy,
    output logic          video_ovr
);

    logic [4:0]    vcnt;
    logic [AW-1:0] vaddr;
    logic [4:0]    cnt_eff;
    logic [AW-1:0] addr_eff;
    logic          grant;
    logic [1:0]    gsrc;
    logic [AW-1:0] gaddr;
    logic          grnw;
    logic [3:0]    pre_p0;
    logic          vld_p0;
    logic [1:0]    src_p0;
    logic [3:0]    next_strb;

    // A video_go in the decision cycle is visible to that same decision.
    always_comb begin
        cnt_eff  = video_go ? video_bw : vcnt;
        addr_eff = video_go ? video_addr : vaddr;
        grant    = 1'b0;
        gsrc     = SRC_VID;
        gaddr    = addr_eff;
        grnw     = 1'b1;
        if (slot) begin
            if (cnt_eff != '0) begin
                grant = 1'b1;
            end else if (tm_req) begin
                grant = 1'b1; gsrc = SRC_TM;  gaddr = tm_addr;
            end else if (ts_lp && cpu_req) begin
                grant = 1'b1; gsrc = SRC_CPU; gaddr = cpu_addr; grnw = cpu_rnw;
            end else if (ts_req) begin
                grant = 1'b1; gsrc = SRC_TS;  gaddr = ts_addr;
            end else if (cpu_req) begin
                grant = 1'b1; gsrc = SRC_CPU; gaddr = cpu_addr; grnw = cpu_rnw;
            end
        end
    end

    // Grant stage: registered request, strobes and pipeline entry
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            vcnt       <= '0;
            vaddr      <= '0;
            dram_req   <= 1'b0;
            dram_addr  <= '0;
            dram_rnw   <= 1'b1;
            pre_p0     <= '0;
            vld_p0     <= 1'b0;
            video_busy <= 1'b0;
            video_ovr  <= 1'b0;
        end else begin
            video_ovr <= video_go && (vcnt != '0);
            dram_req  <= grant;
            pre_p0    <= grant ? src_onehot(gsrc) : 4'b0000;
            vld_p0    <= grant && !(gsrc == SRC_CPU && !grnw);
            if (grant) begin
                dram_addr <= gaddr;
                dram_rnw  <= grnw;
            end
            if (grant && gsrc == SRC_VID) begin
                vcnt       <= cnt_eff - 5'd1;
                vaddr      <= addr_eff + AW'(1);
                video_busy <= (cnt_eff != 5'd1);
            end else begin
                vcnt       <= cnt_eff;
                vaddr      <= addr_eff;
                video_busy <= (cnt_eff != '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        src_p0 <= gsrc;
    end

    video_sched_pipe #(.RD_LAT(RD_LAT)) u_pipe (
        .clk    (clk),
        .res    (res),
        .in_vld (vld_p0),
        .in_src (src_p0),
        .next   (next_strb)
    );

    assign video_pre_next = pre_p0[SRC_VID];
    assign tm_pre_next    = pre_p0[SRC_TM];
    assign ts_pre_next    = pre_p0[SRC_TS];
    assign cpu_pre_next   = pre_p0[SRC_CPU];
    assign video_next     = next_strb[SRC_VID];
    assign tm_next        = next_strb[SRC_TM];
    assign ts_next        = next_strb[SRC_TS];
    assign cpu_next       = next_strb[SRC_CPU];

endmodule

// File: tb/tb_video_dram_sched.sv
// Bench for video_dram_sched: directed scenarios plus random traffic against a slot-level model.
module tb_video_dram_sched;

    localparam int AW     = 21;
    localparam int RD_LAT = 2;

    logic          clk = 1'b0;
    logic          res = 1'b1;
    logic          slot = 1'b0;
    logic          video_go = 1'b0;
    logic [AW-1:0] video_addr = '0;
    logic [4:0]    video_bw = '0;
    logic          tm_req = 1'b0;
    logic [AW-1:0] tm_addr = '0;
    logic          ts_req = 1'b0;
    logic [AW-1:0] ts_addr = '0;
    logic          ts_lp = 1'b0;
    logic          cpu_req = 1'b0;
    logic          cpu_rnw = 1'b1;
    logic [AW-1:0] cpu_addr = '0;

    logic          dram_req, dram_rnw;
    logic [AW-1:0] dram_addr;
    logic          video_pre_next, tm_pre_next, ts_pre_next, cpu_pre_next;
    logic          video_next, tm_next, ts_next, cpu_next;
    logic          video_busy, video_ovr;

    always #5 clk = ~clk;

    video_dram_sched #(.AW(AW), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .res(res), .slot(slot), .video_go(video_go),
        .video_addr(video_addr), .video_bw(video_bw),
        .tm_req(tm_req), .tm_addr(tm_addr), .ts_req(ts_req), .ts_addr(ts_addr),
        .ts_lp(ts_lp), .cpu_req(cpu_req), .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr),
        .dram_req(dram_req), .dram_addr(dram_addr), .dram_rnw(dram_rnw),
        .video_pre_next(video_pre_next), .tm_pre_next(tm_pre_next),
        .ts_pre_next(ts_pre_next), .cpu_pre_next(cpu_pre_next),
        .video_next(video_next), .tm_next(tm_next), .ts_next(ts_next), .cpu_next(cpu_next),
        .video_busy(video_busy), .video_ovr(video_ovr)
    );

    int n_chk = 0;
    int n_err = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
        n_chk++;
        if (act !== req_v) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req_v, $time);
        end
    endfunction

    // Reference model: burst words left, next burst address, and a time-indexed schedule of strobes.
    int            m_cnt = 0;
    int            m_addr = 0;
    int            cyc = 0;
    logic          e_req = 1'b0, e_rnw = 1'b1, e_busy = 1'b0, e_ovr = 1'b0;
    logic [3:0]    e_pre = '0;
    logic [AW-1:0] e_addr = '0;
    logic [3:0]    e_next [16] = '{default: 4'b0000};

    function automatic void model_reset();
        m_cnt = 0; m_addr = 0;
        e_req = 1'b0; e_pre = '0; e_addr = '0; e_rnw = 1'b1; e_busy = 1'b0; e_ovr = 1'b0;
        for (int i = 0; i < 16; i++) e_next[i] = 4'b0000;
    endfunction

    function automatic void model_step();
        int g;
        cyc++;
        e_ovr = video_go && (m_cnt != 0);
        if (video_go) begin
            m_cnt  = int'(video_bw);
            m_addr = int'(video_addr);
        end
        g = -1;
        if (slot) begin
            if (m_cnt > 0)    g = 0;
            else if (tm_req)  g = 1;
            else if (ts_lp)   g = cpu_req ? 3 : (ts_req ? 2 : -1);
            else              g = ts_req ? 2 : (cpu_req ? 3 : -1);
        end
        e_req = (g >= 0);
        e_pre = (g >= 0) ? 4'(1 << g) : 4'b0000;
        case (g)
            0: begin
                e_addr = AW'(m_addr); e_rnw = 1'b1;
                m_addr = (m_addr + 1) % (1 << AW);
                m_cnt  = m_cnt - 1;
            end
            1: begin e_addr = tm_addr;  e_rnw = 1'b1; end
            2: begin e_addr = ts_addr;  e_rnw = 1'b1; end
            3: begin e_addr = cpu_addr; e_rnw = cpu_rnw; end
            default: ;
        endcase
        e_next[(cyc + RD_LAT) % 16] = (g >= 0 && !(g == 3 && !cpu_rnw)) ? e_pre : 4'b0000;
        e_busy = (m_cnt != 0);
    endfunction

    initial forever begin
        @(posedge clk or posedge res);
        if (res) model_reset();
        else     model_step();
    end

    // Compare process: every cycle, mid-period
    initial forever begin
        @(negedge clk);
        chk("dram_req",   dram_req,   e_req);
        chk("dram_addr",  dram_addr,  e_addr);
        chk("dram_rnw",   dram_rnw,   e_rnw);
        chk("pre_next",   {cpu_pre_next, ts_pre_next, tm_pre_next, video_pre_next}, e_pre);
        chk("next",       {cpu_next, ts_next, tm_next, video_next}, e_next[cyc % 16]);
        chk("video_busy", video_busy, e_busy);
        chk("video_ovr",  video_ovr,  e_ovr);
    end

    int vnext_cnt = 0;
    initial forever begin
        @(negedge clk);
        if (video_next) vnext_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_slot();
        slot = 1'b1;
        tick();
        slot = 1'b0;
    endtask

    int base;

    initial begin
        repeat (3) tick();
        res = 1'b0;
        tick();
        chk("rst_rnw", dram_rnw, 1'b1);
        chk("rst_busy", video_busy, 1'b0);

        // Burst of 4 then tile map
        video_addr = 21'h01000; video_bw = 5'd4; video_go = 1'b1;
        tm_req = 1'b1; tm_addr = 21'h0ABCD;
        tick();
        video_go = 1'b0;
        for (int i = 0; i < 6; i++) begin
            do_slot();
            chk("t1_req",   dram_req, 1'b1);
            chk("t1_addr",  dram_addr, (i < 4) ? 32'h01000 + i : 32'h0ABCD);
            chk("t1_vpre",  video_pre_next, i < 4);
            chk("t1_tmpre", tm_pre_next, i >= 4);
            chk("t1_busy",  video_busy, i < 3);
            chk("t1_vnext", video_next, i >= 1 && i <= 4);
            tick();
        end
        tm_req = 1'b0;
        repeat (3) tick();

        // TS vs CPU ordering
        ts_req = 1'b1; ts_addr = 21'h00222; cpu_req = 1'b1; cpu_rnw = 1'b1; cpu_addr = 21'h00333;
        ts_lp = 1'b0;
        do_slot();
        chk("t2_ts_first", ts_pre_next, 1'b1);
        chk("t2_cpu_wait", cpu_pre_next, 1'b0);
        chk("t2_addr", dram_addr, 21'h00222);
        ts_lp = 1'b1;
        tick();
        do_slot();
        chk("t2_cpu_first", cpu_pre_next, 1'b1);
        chk("t2_ts_wait", ts_pre_next, 1'b0);
        chk("t2_ovr", video_ovr, 1'b0);
        ts_req = 1'b0; cpu_req = 1'b0;
        repeat (3) tick();

        // Zero-length burst
        video_addr = 21'h00055; video_bw = 5'd0; video_go = 1'b1;
        tick();
        video_go = 1'b0;
        do_slot();
        chk("t3_req", dram_req, 1'b0);
        chk("t3_busy", video_busy, 1'b0);
        repeat (3) tick();

        // Overrun: new burst replaces old, in-flight words still delivered
        base = vnext_cnt;
        video_addr = 21'h02000; video_bw = 5'd8; video_go = 1'b1;
        tick();
        video_go = 1'b0;
        for (int i = 0; i < 3; i++) begin
            do_slot();
            tick();
        end
        video_addr = 21'h03000; video_bw = 5'd2; video_go = 1'b1;
        tick();
        video_go = 1'b0;
        chk("t4_ovr", video_ovr, 1'b1);
        tick();
        chk("t4_ovr_end", video_ovr, 1'b0);
        do_slot();
        chk("t4_addr0", dram_addr, 21'h03000);
        tick();
        do_slot();
        chk("t4_addr1", dram_addr, 21'h03001);
        chk("t4_busy", video_busy, 1'b0);
        repeat (4) tick();
        chk("t4_vnext_cnt", vnext_cnt - base, 5);

        // Reset with two grants in flight
        video_addr = 21'h04000; video_bw = 5'd6; video_go = 1'b1;
        tick();
        video_go = 1'b0;
        slot = 1'b1;
        tick();
        tick();
        slot = 1'b0;
        res = 1'b1;
        #1;
        chk("t5_req", dram_req, 1'b0);
        chk("t5_vpre", video_pre_next, 1'b0);
        chk("t5_busy", video_busy, 1'b0);
        chk("t5_addr", dram_addr, 0);
        chk("t5_rnw", dram_rnw, 1'b1);
        tick();
        tick();
        res = 1'b0;
        base = vnext_cnt;
        repeat (5) tick();
        chk("t5_no_next", vnext_cnt - base, 0);

        // CPU write
        cpu_req = 1'b1; cpu_rnw = 1'b0; cpu_addr = 21'h01234;
        do_slot();
        chk("t6_rnw", dram_rnw, 1'b0);
        chk("t6_cpre", cpu_pre_next, 1'b1);
        chk("t6_addr", dram_addr, 21'h01234);
        cpu_req = 1'b0; cpu_rnw = 1'b1;
        tick();
        chk("t6_cnext", cpu_next, 1'b0);
        tick();
        chk("t6_cnext2", cpu_next, 1'b0);

        // video_go coinciding with slot
        video_addr = 21'h05000; video_bw = 5'd1; video_go = 1'b1; slot = 1'b1;
        tick();
        video_go = 1'b0; slot = 1'b0;
        chk("t7_addr", dram_addr, 21'h05000);
        chk("t7_vpre", video_pre_next, 1'b1);
        chk("t7_busy", video_busy, 1'b0);
        repeat (3) tick();

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            slot       = ($urandom % 3) == 0;
            video_go   = ($urandom % 25) == 0;
            video_bw   = 5'($urandom % 8);
            video_addr = (($urandom % 4) == 0) ? 21'h1FFFFE : AW'($urandom);
            tm_req     = ($urandom % 5) == 0;
            tm_addr    = AW'($urandom);
            ts_req     = ($urandom % 3) == 0;
            ts_addr    = AW'($urandom);
            ts_lp      = 1'($urandom);
            cpu_req    = ($urandom % 3) == 0;
            cpu_rnw    = 1'($urandom);
            cpu_addr   = AW'($urandom);
            res        = (i >= 2000 && i < 2002);
            tick();
        end
        slot = 1'b0; video_go = 1'b0; tm_req = 1'b0; ts_req = 1'b0; cpu_req = 1'b0; res = 1'b0;
        repeat (6) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
